memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/rv32ima_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 38 +++
 rtl/memory_controller.sv | 156 +++++++++++++++
 tb/tb_memory_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared memory-access types for the rv32ima core.
// Width decode and alignment helpers live here so every user agrees.
package rv32ima_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;

    function automatic mem_width_t decode_width(input logic [1:0] w);
        unique case (w)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic misaligned(input mem_width_t w,
                                        input logic [1:0] off);
        unique case (w)
            HALF:    return off[0];
            WORD:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-justified core data and the 32-bit RAM.
// Purely combinational; the controller registers what it needs.
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  mem_width_t        width,
    input  logic [1:0]        offset,
    input  logic [31:0]       store,
    input  logic [31:0]       rdata,
    output logic [BE_W-1:0]   be,
    output logic [31:0]       wdata,
    output logic [31:0]       load
);

    always_comb begin
        be    = 4'b1111;
        wdata = store;
        load  = rdata;
        unique case (width)
            BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{store[7:0]}};
                load  = {24'b0, rdata[{offset, 3'b000} +: 8]};
            end
            HALF: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store[15:0]}};
                load  = {16'b0, offset[1] ? rdata[31:16] : rdata[15:0]};
            end
            default: begin
                be    = 4'b1111;
                wdata = store;
                load  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/memory_controller.sv
// Arbitrates instruction fetches and data accesses onto one RAM port.
// Each access is registered on leaving IDLE and held until ram_ready.
module memory_controller
    import rv32ima_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ren,
    input  logic [31:0]       imem_addr,
    output logic [31:0]       imem_load,
    output logic              ihit,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_store,
    input  logic [2:0]        dmem_width,
    output logic [31:0]       dmem_load,
    output logic              dhit,
    output logic              dmem_err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [BE_W-1:0]   ram_be,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {IDLE, IREQ, DREQ, IRESP, DRESP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    mem_width_t      width_q, width_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic            store_q, store_d;
    logic            err_q, err_d;
    logic [31:0]     imem_load_q, imem_load_d;
    logic [31:0]     dmem_load_q, dmem_load_d;

    mem_width_t      in_width, lane_width;
    logic [1:0]      lane_off;
    logic [BE_W-1:0] lane_be;
    logic [31:0]     lane_wdata, lane_load;
    logic            take_d, in_req;
    logic            unused_width;

    assign unused_width = dmem_width[2];
    assign in_width     = decode_width(dmem_width[1:0]);

    // Live inputs in IDLE build the store lanes; the held access decodes loads.
    assign lane_width = (state_q == IDLE) ? in_width : width_q;
    assign lane_off   = (state_q == IDLE) ? dmem_addr[1:0] : addr_q[1:0];

    mem_lane_align u_lane (
        .width  (lane_width),
        .offset (lane_off),
        .store  (dmem_store),
        .rdata  (ram_rdata),
        .be     (lane_be),
        .wdata  (lane_wdata),
        .load   (lane_load)
    );

    assign take_d = (dmem_ren | dmem_wen) & (DATA_FIRST | ~imem_ren);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        width_d     = width_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        store_d     = store_q;
        err_d       = err_q;
        imem_load_d = imem_load_q;
        dmem_load_d = dmem_load_q;
        unique case (state_q)
            IDLE: begin
                if (take_d) begin
                    addr_d  = dmem_addr;
                    width_d = in_width;
                    wdata_d = lane_wdata;
                    be_d    = lane_be;
                    store_d = dmem_wen;
                    err_d   = misaligned(in_width, dmem_addr[1:0]);
                    if (err_d) begin
                        dmem_load_d = '0;
                        state_d     = DRESP;
                    end else begin
                        state_d = DREQ;
                    end
                end else if (imem_ren) begin
                    addr_d  = imem_addr;
                    width_d = WORD;
                    wdata_d = '0;
                    be_d    = '1;
                    store_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IREQ;
                end
            end
            IREQ: begin
                if (ram_ready) begin
                    imem_load_d = ram_rdata;
                    state_d     = IRESP;
                end
            end
            DREQ: begin
                if (ram_ready) begin
                    dmem_load_d = store_q ? 32'b0 : lane_load;
                    state_d     = DRESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            width_q     <= BYTE;
            wdata_q     <= '0;
            be_q        <= '0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            imem_load_q <= '0;
            dmem_load_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            store_q     <= store_d;
            err_q       <= err_d;
            imem_load_q <= imem_load_d;
            dmem_load_q <= dmem_load_d;
        end
    end

    assign in_req    = (state_q == IREQ) | (state_q == DREQ);
    assign ram_ren   = (state_q == IREQ) | ((state_q == DREQ) & ~store_q);
    assign ram_wen   = (state_q == DREQ) & store_q;
    assign ram_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign ram_wdata = in_req ? wdata_q : 32'b0;
    assign ram_be    = in_req ? be_q : '0;
    assign ihit      = (state_q == IRESP);
    assign dhit      = (state_q == DRESP);
    assign dmem_err  = (state_q == DRESP) & err_q;
    assign imem_load = imem_load_q;
    assign dmem_load = dmem_load_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: fetch, lanes, priority, errors, reset.
// A second instance with DATA_FIRST=0 covers the reversed arbitration order.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren, dmem_ren, dmem_wen;
    logic [31:0] imem_addr, dmem_addr, dmem_store, ram_rdata;
    logic [2:0]  dmem_width;
    logic        ram_ready, ram_ready_man, auto_ready;
    logic [31:0] imem_load, dmem_load, ram_addr, ram_wdata;
    logic        ihit, dhit, dmem_err, ram_ren, ram_wen;
    logic [3:0]  ram_be;

    logic        ireq0, dreq0, ram_ready0;
    logic [31:0] imem_load0, dmem_load0, ram_addr0, ram_wdata0;
    logic        ihit0, dhit0, dmem_err0, ram_ren0, ram_wen0;
    logic [3:0]  ram_be0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ram_ready  = auto_ready ? (ram_ren | ram_wen) : ram_ready_man;
    assign ram_ready0 = ram_ren0 | ram_wen0;

    memory_controller #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_ren(imem_ren), .imem_addr(imem_addr),
        .imem_load(imem_load), .ihit(ihit),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_store(dmem_store),
        .dmem_width(dmem_width), .dmem_load(dmem_load),
        .dhit(dhit), .dmem_err(dmem_err),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    memory_controller #(.DATA_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .imem_ren(ireq0), .imem_addr(imem_addr),
        .imem_load(imem_load0), .ihit(ihit0),
        .dmem_ren(dreq0), .dmem_wen(1'b0),
        .dmem_addr(dmem_addr), .dmem_store(dmem_store),
        .dmem_width(dmem_width), .dmem_load(dmem_load0),
        .dhit(dhit0), .dmem_err(dmem_err0),
        .ram_ren(ram_ren0), .ram_wen(ram_wen0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_be(ram_be0),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {22'b0, ihit, dhit, dmem_err, ram_ren, ram_wen,
                ram_be, ihit0 | dhit0 | ram_ren0 | ram_wen0};
    endfunction

    initial begin
        rst = 1'b1;
        imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
        imem_addr = 0; dmem_addr = 0; dmem_store = 0; dmem_width = 0;
        ram_rdata = 0; ram_ready_man = 0; auto_ready = 0;
        ireq0 = 0; dreq0 = 0;
        tick(); tick();
        chk("rst_ctrl", outs(), 32'h0);
        chk("rst_addr", ram_addr | ram_wdata, 32'h0);
        chk("rst_load", imem_load | dmem_load, 32'h0);
        rst = 1'b0;
        tick();

        // fetch with ram_ready three cycles late
        imem_ren = 1; imem_addr = 32'h104;
        tick();
        chk("f_ren", {31'b0, ram_ren}, 32'h1);
        chk("f_addr", ram_addr, 32'h104);
        tick();
        tick();
        chk("f_wait", {30'b0, ram_ren, ihit}, 32'h2);
        chk("f_addr_hold", ram_addr, 32'h104);
        ram_ready_man = 1; ram_rdata = 32'h00500093;
        tick();
        chk("f_ihit", {30'b0, ihit, ram_ren}, 32'h2);
        chk("f_load", imem_load, 32'h00500093);
        ram_ready_man = 0; imem_ren = 0;
        tick();
        chk("f_pulse", {31'b0, ihit}, 32'h0);

        // byte store, ram_ready already high while idle
        dmem_wen = 1; dmem_addr = 32'h203; dmem_width = 3'b000;
        dmem_store = 32'h123456AB; ram_ready_man = 1;
        tick();
        chk("sb_strobe", {30'b0, ram_wen, ram_ren}, 32'h2);
        chk("sb_be", {28'b0, ram_be}, 32'h8);
        chk("sb_wdata", ram_wdata, 32'hABABABAB);
        chk("sb_addr", ram_addr, 32'h200);
        tick();
        chk("sb_dhit", {29'b0, dhit, dmem_err, ram_wen}, 32'h4);
        dmem_wen = 0; ram_ready_man = 0;
        tick();
        chk("sb_pulse", {31'b0, dhit}, 32'h0);

        // half load at 0x202
        dmem_ren = 1; dmem_addr = 32'h202; dmem_width = 3'b001;
        ram_rdata = 32'hBEEF1234; ram_ready_man = 1;
        tick();
        chk("lh_be", {27'b0, ram_ren, ram_be}, 32'h1C);
        tick();
        chk("lh_dhit", {31'b0, dhit}, 32'h1);
        chk("lh_load", dmem_load, 32'h0000BEEF);
        dmem_ren = 0;
        tick();

        // byte load at 0x201, width[2] set to show it is ignored
        dmem_ren = 1; dmem_addr = 32'h201; dmem_width = 3'b100;
        tick();
        chk("lb_be", {27'b0, ram_ren, ram_be}, 32'h12);
        tick();
        chk("lb_load", dmem_load, 32'h00000012);
        dmem_ren = 0;
        tick();

        // load and store together act as a store
        dmem_ren = 1; dmem_wen = 1; dmem_addr = 32'h300;
        dmem_width = 3'b011; dmem_store = 32'hCAFEF00D;
        tick();
        chk("rw_strobe", {30'b0, ram_wen, ram_ren}, 32'h2);
        chk("rw_be", {28'b0, ram_be}, 32'hF);
        chk("rw_wdata", ram_wdata, 32'hCAFEF00D);
        tick();
        chk("rw_dhit", {31'b0, dhit}, 32'h1);
        dmem_ren = 0; dmem_wen = 0; ram_ready_man = 0;
        tick();

        // misaligned word store skips the RAM
        dmem_wen = 1; dmem_addr = 32'h206; dmem_width = 3'b010;
        dmem_store = 32'h55555555;
        tick();
        chk("mis_hit", {29'b0, dhit, dmem_err, ram_wen}, 32'h6);
        chk("mis_load", dmem_load, 32'h0);
        dmem_wen = 0;
        tick();
        chk("mis_clear", {30'b0, dhit, dmem_err}, 32'h0);

        // contention on both instances with a zero-wait RAM
        auto_ready = 1;
        imem_addr = 32'h100; dmem_addr = 32'h300; dmem_width = 3'b010;
        ram_rdata = 32'h11111111;
        imem_ren = 1; dmem_ren = 1; ireq0 = 1; dreq0 = 1;
        tick();
        chk("c1_addr", ram_addr, 32'h300);
        chk("c0_addr", ram_addr0, 32'h100);
        tick();
        chk("c1_first", {30'b0, dhit, ihit}, 32'h2);
        chk("c0_first", {30'b0, dhit0, ihit0}, 32'h1);
        dmem_ren = 0; ireq0 = 0;
        tick();
        tick();
        chk("c1_addr2", ram_addr, 32'h100);
        chk("c0_addr2", ram_addr0, 32'h300);
        tick();
        chk("c1_second", {30'b0, dhit, ihit}, 32'h1);
        chk("c0_second", {30'b0, dhit0, ihit0}, 32'h2);
        imem_ren = 0; dreq0 = 0;
        tick();
        auto_ready = 0; ram_ready_man = 0;

        // reset while the RAM never answers
        dmem_ren = 1; dmem_addr = 32'h400; dmem_width = 3'b010;
        tick();
        chk("rd_strobe", {31'b0, ram_ren}, 32'h1);
        tick();
        rst = 1;
        tick();
        chk("rd_ctrl", outs(), 32'h0);
        chk("rd_addr", ram_addr | ram_wdata, 32'h0);
        chk("rd_load", imem_load | dmem_load, 32'h0);
        rst = 0; dmem_ren = 0;
        tick();
        chk("rd_nohit", {30'b0, dhit, ram_ren}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
